// File: rtl/tmds_encoder_multi.sv
// Multi-channel TMDS encoder: depth expansion, transition minimisation and DC balance,
// with optional lookahead-driven HDMI video guard-band insertion.
module tmds_encoder_multi #(
    parameter int C_channels = 3,
    parameter int C_depth    = 2,
    parameter int C_guard    = 0
) (
    input  logic                          clk_pixel,
    input  logic                          reset,
    input  logic                          in_blank,
    input  logic [2*C_channels-1:0]       in_ctrl,
    input  logic [C_channels*C_depth-1:0] in_data,
    output logic [10*C_channels-1:0]      out_tmds
);
    localparam logic [9:0] SYM_CTRL_00 = 10'h354;
    localparam logic [9:0] SYM_CTRL_01 = 10'h0AB;
    localparam logic [9:0] SYM_CTRL_10 = 10'h154;
    localparam logic [9:0] SYM_CTRL_11 = 10'h2AB;

    function automatic logic [3:0] count_ones(input logic [7:0] v);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < 8; i++) begin
            c = c + {3'b000, v[i]};
        end
        return c;
    endfunction

    function automatic logic [8:0] transition_min(input logic [7:0] d);
        logic [8:0] q;
        logic       use_xnor;
        logic [3:0] n;
        n        = count_ones(d);
        use_xnor = (n > 4'd4) || ((n == 4'd4) && (d[0] == 1'b0));
        q[0]     = d[0];
        for (int i = 1; i < 8; i++) begin
            q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        end
        q[8] = ~use_xnor;
        return q;
    endfunction

    function automatic logic [9:0] ctrl_symbol(input logic [1:0] c);
        logic [9:0] s;
        case (c)
            2'b00:   s = SYM_CTRL_00;
            2'b01:   s = SYM_CTRL_01;
            2'b10:   s = SYM_CTRL_10;
            2'b11:   s = SYM_CTRL_11;
            default: s = SYM_CTRL_00;
        endcase
        return s;
    endfunction

    logic                          slot_blank_s;
    logic [2*C_channels-1:0]       slot_ctrl_s;
    logic [C_channels*C_depth-1:0] slot_data_s;
    logic                          slot_guard_s;

    logic                          s1_blank_r;
    logic                          s1_guard_r;
    logic [2*C_channels-1:0]       s1_ctrl_r;

    if (C_guard != 0) begin : g_guard
        typedef enum logic [1:0] {ST_CTRL, ST_GUARD1, ST_GUARD2, ST_VIDEO} guard_state_t;
        guard_state_t                  state_r;
        guard_state_t                  state_next_s;
        logic                          dly1_blank_r;
        logic                          dly2_blank_r;
        logic [2*C_channels-1:0]       dly1_ctrl_r;
        logic [2*C_channels-1:0]       dly2_ctrl_r;
        logic [C_channels*C_depth-1:0] dly1_data_r;
        logic [C_channels*C_depth-1:0] dly2_data_r;

        // Two-slot delay line; the undelayed input acts as lookahead for the oldest slot.
        always_ff @(posedge clk_pixel or posedge reset) begin
            if (reset) begin
                dly1_blank_r <= 1'b1;
                dly2_blank_r <= 1'b1;
                dly1_ctrl_r  <= {2*C_channels{1'b0}};
                dly2_ctrl_r  <= {2*C_channels{1'b0}};
                dly1_data_r  <= {C_channels*C_depth{1'b0}};
                dly2_data_r  <= {C_channels*C_depth{1'b0}};
            end else begin
                dly1_blank_r <= in_blank;
                dly2_blank_r <= dly1_blank_r;
                dly1_ctrl_r  <= in_ctrl;
                dly2_ctrl_r  <= dly1_ctrl_r;
                dly1_data_r  <= in_data;
                dly2_data_r  <= dly1_data_r;
            end
        end

        // Guard FSM state register; the state names the mode of the slot last issued.
        always_ff @(posedge clk_pixel or posedge reset) begin
            if (reset) begin
                state_r <= ST_CTRL;
            end else begin
                state_r <= state_next_s;
            end
        end

        // Classify the oldest delayed slot: the last two blank slots before video become guard.
        always_comb begin
            state_next_s = ST_CTRL;
            case (state_r)
                ST_GUARD1: begin
                    if (dly2_blank_r) state_next_s = ST_GUARD2;
                    else              state_next_s = ST_VIDEO;
                end
                ST_CTRL, ST_GUARD2, ST_VIDEO: begin
                    if (!dly2_blank_r)      state_next_s = ST_VIDEO;
                    else if (!dly1_blank_r) state_next_s = ST_GUARD2;
                    else if (!in_blank)     state_next_s = ST_GUARD1;
                    else                    state_next_s = ST_CTRL;
                end
                default: state_next_s = ST_CTRL;
            endcase
        end

        assign slot_blank_s = dly2_blank_r;
        assign slot_ctrl_s  = dly2_ctrl_r;
        assign slot_data_s  = dly2_data_r;
        assign slot_guard_s = (state_next_s == ST_GUARD1) || (state_next_s == ST_GUARD2);
    end else begin : g_direct
        assign slot_blank_s = in_blank;
        assign slot_ctrl_s  = in_ctrl;
        assign slot_data_s  = in_data;
        assign slot_guard_s = 1'b0;
    end

    // Stage 1 control fields shared by all channels.
    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            s1_blank_r <= 1'b1;
            s1_guard_r <= 1'b0;
            s1_ctrl_r  <= {2*C_channels{1'b0}};
        end else begin
            s1_blank_r <= slot_blank_s;
            s1_guard_r <= slot_guard_s;
            s1_ctrl_r  <= slot_ctrl_s;
        end
    end

    for (genvar ch = 0; ch < C_channels; ch++) begin : g_ch
        localparam logic [9:0] SYM_GUARD = (ch == 1) ? 10'h133 : 10'h2CC;

        logic [7:0]        byte_s;
        logic [8:0]        qm_s;
        logic [8:0]        qm_r;
        logic [3:0]        n1_r;
        logic [3:0]        n0_r;
        logic signed [4:0] diff_s;
        logic signed [4:0] cnt_r;
        logic signed [4:0] cnt_next_s;
        logic [9:0]        sym_s;
        logic [9:0]        sym_r;

        // MSB-aligned input pattern repeated down into the low bits.
        for (genvar j = 0; j < 8; j++) begin : g_exp
            assign byte_s[7-j] = slot_data_s[ch*C_depth + C_depth - 1 - (j % C_depth)];
        end

        assign qm_s = transition_min(byte_s);

        // Stage 1: transition-minimised word and its ones/zeros balance.
        always_ff @(posedge clk_pixel or posedge reset) begin
            if (reset) begin
                qm_r <= 9'h000;
                n1_r <= 4'd0;
                n0_r <= 4'd0;
            end else begin
                qm_r <= qm_s;
                n1_r <= count_ones(qm_s[7:0]);
                n0_r <= 4'd8 - count_ones(qm_s[7:0]);
            end
        end

        assign diff_s = $signed({1'b0, n1_r}) - $signed({1'b0, n0_r});

        // Stage 2: DC-balance decision, or control/guard symbol during blanking.
        always_comb begin
            sym_s      = SYM_CTRL_00;
            cnt_next_s = 5'sd0;
            if (s1_blank_r) begin
                if (s1_guard_r) sym_s = SYM_GUARD;
                else            sym_s = ctrl_symbol(s1_ctrl_r[2*ch +: 2]);
                cnt_next_s = 5'sd0;
            end else if ((cnt_r == 5'sd0) || (n1_r == n0_r)) begin
                sym_s      = {~qm_r[8], qm_r[8], (qm_r[8] ? qm_r[7:0] : ~qm_r[7:0])};
                cnt_next_s = qm_r[8] ? (cnt_r + diff_s) : (cnt_r - diff_s);
            end else if (((cnt_r > 5'sd0) && (n1_r > n0_r)) || ((cnt_r < 5'sd0) && (n0_r > n1_r))) begin
                sym_s      = {1'b1, qm_r[8], ~qm_r[7:0]};
                cnt_next_s = cnt_r - diff_s + (qm_r[8] ? 5'sd2 : 5'sd0);
            end else begin
                sym_s      = {1'b0, qm_r[8], qm_r[7:0]};
                cnt_next_s = cnt_r + diff_s - (qm_r[8] ? 5'sd0 : 5'sd2);
            end
        end

        // Stage 2 output symbol and running disparity.
        always_ff @(posedge clk_pixel or posedge reset) begin
            if (reset) begin
                sym_r <= SYM_CTRL_00;
                cnt_r <= 5'sd0;
            end else begin
                sym_r <= sym_s;
                cnt_r <= cnt_next_s;
            end
        end

        assign out_tmds[ch*10 +: 10] = sym_r;
    end

endmodule

// File: tb/tb_tmds_encoder_multi.sv
// Scoreboard bench: three encoder configurations share stimulus; a spec-level model
// predicts each output symbol and a monitor compares as symbols emerge.
module tb_tmds_encoder_multi;
    logic        clk_pixel = 1'b0;
    logic        reset;
    logic        in_blank;
    logic [5:0]  in_ctrl;
    logic [23:0] raw;
    logic [5:0]  data_a;
    logic [23:0] data_b;
    logic [8:0]  data_c;
    logic [29:0] out_a;
    logic [29:0] out_b;
    logic [29:0] out_c;

    always #5 clk_pixel = ~clk_pixel;

    assign data_a = {raw[17:16], raw[9:8], raw[1:0]};
    assign data_b = raw;
    assign data_c = {raw[18:16], raw[10:8], raw[2:0]};

    tmds_encoder_multi #(.C_channels(3), .C_depth(2), .C_guard(0)) dut_a (
        .clk_pixel(clk_pixel), .reset(reset), .in_blank(in_blank),
        .in_ctrl(in_ctrl), .in_data(data_a), .out_tmds(out_a));
    tmds_encoder_multi #(.C_channels(3), .C_depth(8), .C_guard(1)) dut_b (
        .clk_pixel(clk_pixel), .reset(reset), .in_blank(in_blank),
        .in_ctrl(in_ctrl), .in_data(data_b), .out_tmds(out_b));
    tmds_encoder_multi #(.C_channels(3), .C_depth(3), .C_guard(0)) dut_c (
        .clk_pixel(clk_pixel), .reset(reset), .in_blank(in_blank),
        .in_ctrl(in_ctrl), .in_data(data_c), .out_tmds(out_c));

    typedef struct packed {
        int          due;
        logic [29:0] val;
    } exp_t;

    exp_t        sb[3][$];
    int          edge_cnt = 0;
    int          vectors = 0;
    int          miscompares = 0;
    int          cnt_m[3][3];
    bit          hist_blank[2];
    logic [5:0]  hist_ctrl[2];
    logic [23:0] hist_raw[2];
    int          depth_of[3] = '{2, 8, 3};
    logic [9:0]  ctrl_lut[4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};
    string       dut_name[3] = '{"dut_a_d2", "dut_b_d8_guard", "dut_c_d3"};

    always @(posedge clk_pixel) edge_cnt <= edge_cnt + 1;

    function automatic logic [29:0] dut_out(input int d);
        case (d)
            0:       return out_a;
            1:       return out_b;
            default: return out_c;
        endcase
    endfunction

    // Replicate the low 'depth' bits end to end and keep the top eight.
    function automatic logic [7:0] expand(input logic [7:0] r, input int depth);
        int acc  = 0;
        int bits = 0;
        int pat  = int'(r) & ((1 << depth) - 1);
        while (bits < 8) begin
            acc  = (acc << depth) | pat;
            bits = bits + depth;
        end
        return 8'(acc >> (bits - 8));
    endfunction

    function automatic logic [9:0] encode(input int d, input int ch, input logic [7:0] b);
        int         ones = $countones(b);
        bit         use_xnor = (ones > 4) || (ones == 4 && b[0] == 1'b0);
        logic [8:0] q;
        logic [9:0] sym;
        int         n1;
        int         n0;
        int         c = cnt_m[d][ch];
        q[0] = b[0];
        for (int i = 1; i < 8; i++) q[i] = use_xnor ? (q[i-1] ~^ b[i]) : (q[i-1] ^ b[i]);
        q[8] = !use_xnor;
        n1 = $countones(q[7:0]);
        n0 = 8 - n1;
        if (c == 0 || n1 == n0) begin
            sym = {~q[8], q[8], (q[8] ? q[7:0] : ~q[7:0])};
            c   = c + (q[8] ? (n1 - n0) : (n0 - n1));
        end else if ((c > 0 && n1 > n0) || (c < 0 && n0 > n1)) begin
            sym = {1'b1, q[8], ~q[7:0]};
            c   = c + (q[8] ? 2 : 0) + (n0 - n1);
        end else begin
            sym = {1'b0, q[8], q[7:0]};
            c   = c + (n1 - n0) - (q[8] ? 0 : 2);
        end
        cnt_m[d][ch] = c;
        return sym;
    endfunction

    function automatic logic [29:0] slot_out(input int d, input bit blank, input logic [5:0] ctrl,
                                             input logic [23:0] r, input bit guard);
        logic [29:0] w;
        for (int ch = 0; ch < 3; ch++) begin
            if (blank) begin
                cnt_m[d][ch] = 0;
                if (guard) w[10*ch +: 10] = (ch == 1) ? 10'h133 : 10'h2CC;
                else       w[10*ch +: 10] = ctrl_lut[ctrl[2*ch +: 2]];
            end else begin
                w[10*ch +: 10] = encode(d, ch, expand(r[8*ch +: 8], depth_of[d]));
            end
        end
        return w;
    endfunction

    task automatic reset_model();
        for (int d = 0; d < 3; d++) for (int ch = 0; ch < 3; ch++) cnt_m[d][ch] = 0;
        for (int k = 0; k < 2; k++) begin
            hist_blank[k] = 1'b1;
            hist_ctrl[k]  = 6'h00;
            hist_raw[k]   = 24'h000000;
        end
    endtask

    task automatic check(input string nm, input logic [29:0] got, input logic [29:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (edge %0d)", nm, got, exp, edge_cnt);
        end
    endtask

    task automatic check_reset(input string nm);
        for (int d = 0; d < 3; d++) check({nm, "_", dut_name[d]}, dut_out(d), {3{10'h354}});
    endtask

    // A slot applied now is captured at edge cap; its symbol is due one edge later.
    // In guard mode the symbol due then belongs to the slot two inputs back.
    task automatic apply(input bit b, input logic [5:0] c, input logic [23:0] r);
        int cap;
        bit guard;
        @(negedge clk_pixel);
        in_blank = b;
        in_ctrl  = c;
        raw      = r;
        cap      = edge_cnt + 1;
        sb[0].push_back('{due: cap + 1, val: slot_out(0, b, c, r, 1'b0)});
        sb[2].push_back('{due: cap + 1, val: slot_out(2, b, c, r, 1'b0)});
        guard = hist_blank[1] && (!hist_blank[0] || !b);
        sb[1].push_back('{due: cap + 1, val: slot_out(1, hist_blank[1], hist_ctrl[1], hist_raw[1], guard)});
        hist_blank[1] = hist_blank[0];
        hist_ctrl[1]  = hist_ctrl[0];
        hist_raw[1]   = hist_raw[0];
        hist_blank[0] = b;
        hist_ctrl[0]  = c;
        hist_raw[0]   = r;
    endtask

    task automatic do_reset();
        @(negedge clk_pixel);
        #2 reset = 1'b1;
        #1 check_reset("midframe_reset");
        for (int d = 0; d < 3; d++) sb[d].delete();
        reset_model();
        in_blank = 1'b1;
        in_ctrl  = 6'h00;
        raw      = 24'h000000;
        @(negedge clk_pixel);
        reset = 1'b0;
    endtask

    // Monitor: compare every due symbol just after the edge that produced it.
    initial begin
        forever begin
            @(posedge clk_pixel);
            #1;
            for (int d = 0; d < 3; d++) begin
                while (sb[d].size() > 0 && sb[d][0].due <= edge_cnt) begin
                    if (sb[d][0].due == edge_cnt) begin
                        check(dut_name[d], dut_out(d), sb[d][0].val);
                    end else begin
                        vectors++;
                        miscompares++;
                        $display("FAIL %s_late: symbol due at edge %0d not compared, expected %h",
                                 dut_name[d], sb[d][0].due, sb[d][0].val);
                    end
                    void'(sb[d].pop_front());
                end
            end
        end
    end

    initial begin
        reset    = 1'b1;
        in_blank = 1'b1;
        in_ctrl  = 6'h00;
        raw      = 24'h000000;
        reset_model();
        #1 check_reset("power_on_reset");
        repeat (2) @(negedge clk_pixel);
        reset = 1'b0;

        for (int c = 0; c < 4; c++) apply(1'b1, 6'(c), 24'h000000);
        repeat (4) apply(1'b0, 6'h00, 24'hFFFFFF);
        apply(1'b1, 6'h00, 24'h000000);
        repeat (2) apply(1'b0, 6'h00, 24'h000000);
        apply(1'b1, 6'h00, 24'h000000);
        apply(1'b0, 6'h00, 24'h000000);
        repeat (3) apply(1'b1, 6'h00, 24'h000000);
        repeat (2) apply(1'b0, 6'h00, 24'h050505);

        repeat (5) apply(1'b1, 6'h1B, 24'h000000);
        repeat (3) apply(1'b0, 6'h00, 24'($urandom));
        apply(1'b1, 6'h02, 24'h000000);
        repeat (3) apply(1'b0, 6'h00, 24'($urandom));
        apply(1'b1, 6'h00, 24'h000000);
        apply(1'b1, 6'h00, 24'h000000);
        repeat (2) apply(1'b0, 6'h00, 24'($urandom));

        for (int v = 0; v < 256; v++) apply(1'b0, 6'h00, {8'(v + 170), 8'(v + 85), 8'(v)});

        for (int seg = 0; seg < 60; seg++) begin
            int act = $urandom_range(1, 25);
            int bl  = $urandom_range(0, 6);
            repeat (act) apply(1'b0, 6'($urandom), 24'($urandom));
            repeat (bl) apply(1'b1, 6'($urandom), 24'($urandom));
        end

        repeat (5) apply(1'b0, 6'h00, 24'($urandom));
        do_reset();
        repeat (2) apply(1'b1, 6'h00, 24'h000000);
        repeat (3) apply(1'b0, 6'h00, 24'h000000);

        repeat (4) apply(1'b1, 6'h00, 24'h000000);
        repeat (3) @(negedge clk_pixel);
        for (int d = 0; d < 3; d++) begin
            vectors++;
            if (sb[d].size() != 0) begin
                miscompares++;
                $display("FAIL %s_drain: %0d symbols left uncompared, expected 0", dut_name[d], sb[d].size());
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
